// File: rtl/counter_pkg.sv
// Shared defaults for the up/down counter family.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam logic [7:0]  DEFAULT_RESET_VAL = 8'hFF;

endpackage

// File: rtl/down_counter_dec.sv
// Combinational borrow-chain decrementer with zero/one detection.
module down_counter_dec
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             is_zero,
  output logic             is_one
);

  logic borrow;

  // Ripple borrow: a bit flips while every lower bit was zero.
  always_comb begin
    diff   = '0;
    borrow = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ borrow;
      borrow  = borrow & ~a[i];
    end
  end

  assign is_zero = (a == '0);
  assign is_one  = (a == WIDTH'(1));

endmodule

// File: rtl/down_counter_reload.sv
// Loadable enable-gated down counter with terminal-count pulse, auto-reload
// or saturate-at-zero behaviour, and a sticky underflow flag.
module down_counter_reload
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             clr_uf,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             underflow
);

  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] dec_diff;
  logic [WIDTH-1:0] count_n;
  logic             dec_zero;
  logic             dec_one;
  logic             tc_n;
  logic             uf_n;

  down_counter_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a      (count),
    .diff   (dec_diff),
    .is_zero(dec_zero),
    .is_one (dec_one)
  );

  // The zero case never reaches the decrementer: it reloads or saturates.
  always_comb begin
    count_n = count;
    tc_n    = 1'b0;
    uf_n    = clr_uf ? 1'b0 : underflow;
    if (load) begin
      count_n = load_val;
    end else if (en) begin
      if (!dec_zero) begin
        count_n = dec_diff;
        tc_n    = dec_one;
      end else if (auto_reload) begin
        count_n = reload_reg;
        tc_n    = (reload_reg == '0);
      end else begin
        count_n = '0;
        tc_n    = 1'b1;
        uf_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= RESET_VAL;
      reload_reg <= RESET_VAL;
      zero       <= (RESET_VAL == '0);
      tc         <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count     <= count_n;
      zero      <= (count_n == '0);
      tc        <= tc_n;
      underflow <= uf_n;
      if (load) begin
        reload_reg <= load_val;
      end
    end
  end

endmodule
